fabosc_clkdiv_gen: RTL and testbench
====================================

# fabosc_clkdiv_gen

Parametrised multi-channel clock-enable and divided-clock generator running on the fabric oscillator clock (RCOSC 50 MHz via CLKINT). Each channel produces a one-cycle TICK strobe and a registered 50%-duty CLK_OUT. Both derive from a runtime-programmable divisor. Divisor changes are double-buffered and commit only at a terminal count, so outputs never glitch. A global ALIGN restarts every channel in phase.

## Interface
- NUM_CH, 4: number of independent divider channels (1..16).
- DIV_W, 16: divisor and counter width in bits.
- RESET_DIV, 49: divisor-minus-one loaded at reset; 49 gives a 1 MHz TICK from 50 MHz.
- CH_W, max(1, clog2(NUM_CH)): derived width of CFG_CH; not overridden.

- CLK  in  1  fabric oscillator clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- EN  in  NUM_CH  per-channel run enable.
- ALIGN  in  1  synchronous restart of all channels; one-cycle pulse.
- CFG_WE  in  1  divisor write strobe.
- CFG_CH  in  CH_W  channel index for the write.
- CFG_DIV  in  DIV_W  new divisor-minus-one (D); output period is D+1 cycles.
- CFG_PEND  out  NUM_CH  shadow divisor written but not yet committed.
- TICK  out  NUM_CH  one-cycle strobe every D+1 enabled cycles.
- CLK_OUT  out  NUM_CH  registered square wave that toggles on each TICK; period 2(D+1).

## Operation
- Per-channel state:
  - active divisor A (DIV_W)
  - shadow S (DIV_W)
  - pending P (reflected on CFG_PEND)
  - counter C (DIV_W)
  - TICK register
  - CLK_OUT register
- Reset values: A = S = RESET_DIV, P = 0, C = 0, TICK = 0, CLK_OUT = 0 on all channels.
- Priority per edge: RESET > ALIGN > EN-low handling > count.
- Config write: when CFG_WE = 1 and CFG_CH < NUM_CH, S[CFG_CH] <= CFG_DIV and P[CFG_CH] <= 1. If CFG_CH >= NUM_CH, the write is ignored and no state changes.
- Count, when EN[i] = 1 and ALIGN = 0:
  - If C == A: C <= 0, TICK <= 1, CLK_OUT toggles. If P = 1, also A <= S and P <= 0.
  - Otherwise: C <= C + 1 and TICK <= 0.
- EN[i] = 0:
  - C <= 0 and TICK <= 0; CLK_OUT holds its level.
  - If P = 1: A <= S and P <= 0 (an immediate commit is safe while stopped).
- ALIGN = 1, all channels regardless of EN:
  - C <= 0, TICK <= 0, CLK_OUT <= 0.
  - A pending shadow commits: A <= S, P <= 0.
- Simultaneous events: all decisions use register values from before the edge.
  - A write in the same cycle as a commit (terminal count, EN low or ALIGN) on the same channel: A takes the old S. The new value is stored in S and P ends at 1, so it commits at the next terminal count.
  - Multiple writes before a commit: the last one wins.
- Invariant: C <= A always, because A only changes on the edge where C is forced to 0. The comparison is equality only, and there is no wrap-around path.
- D = 0: TICK stays high continuously while enabled, and CLK_OUT = CLK/2.
- D = 2^DIV_W - 1: the counter reaches all-ones and then returns to 0; the +1 never overflows.

## Timing
- All outputs are registered, with no combinational path from input to output.
- First TICK: with EN high and C = 0, TICK is high for the cycle following the (A+1)th enabled edge. It then repeats every A+1 cycles.
- ALIGN deasserted at edge k with EN high: every channel's first TICK follows edge k + A + 1. All channels sharing a divisor stay phase-locked after that.
- Divisor change latency:
  - CFG_PEND rises one cycle after CFG_WE.
  - The commit happens at the channel's next terminal count, at most A + 1 cycles later.
  - The first period at the new divisor starts immediately after the commit.
- The current period always completes at the old divisor; no TICK is dropped or shortened.
- RESET mid-period forces all outputs low on the next edge. A pending write is discarded.

## Test plan
- Reset then EN = 4'b1111 with defaults: TICK pulses at cycles 50, 100, 150. CLK_OUT has a 100-cycle period. CFG_PEND = 0.
- Channel 1 running at D = 9: write D = 3 while C = 5. The ticks at C = 9 still arrive on schedule, CFG_PEND[1] clears at that tick, and the following ticks are 4 cycles apart.
- Write to channel 2 in the same cycle as its terminal count. The old S is committed, CFG_PEND[2] stays 1, and the new value commits one period later.
- Channels 0 and 3 at D = 2 and D = 5, ALIGN pulsed mid-count. Both CLK_OUT go 0, and the next TICKs occur 3 and 6 cycles after ALIGN and coincide every 6 cycles.
- D = 0 on channel 0: TICK is held high and CLK_OUT toggles every cycle. Drop EN: TICK goes 0 next cycle and CLK_OUT freezes.
- Write with CFG_CH = 4 when NUM_CH = 4: no state change. Then assert RESET mid-count with a pending write: all outputs 0, A = 49, P = 0.

Source files
------------

// File: rtl/fabosc_clkdiv_gen.sv
// fabosc_clkdiv_gen: multi-channel clock-enable / divided-clock generator.
// Each channel counts 0..A and emits a one-cycle TICK on the terminal count,
// toggling a registered CLK_OUT at the same edge. New divisors are written to
// a shadow register and only take effect on an edge where the counter is
// forced back to zero (terminal count, channel stopped, or global align), so
// a period in progress is never cut short or stretched.
module fabosc_clkdiv_gen #(
    parameter int NUM_CH    = 4,
    parameter int DIV_W     = 16,
    parameter int RESET_DIV = 49,
    parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [NUM_CH-1:0] en_i,
    input  logic              align_i,
    input  logic              cfg_we_i,
    input  logic [CH_W-1:0]   cfg_ch_i,
    input  logic [DIV_W-1:0]  cfg_div_i,
    output logic [NUM_CH-1:0] cfg_pend_o,
    output logic [NUM_CH-1:0] tick_o,
    output logic [NUM_CH-1:0] clk_out_o
);

    localparam logic [DIV_W-1:0] RST_A = DIV_W'(RESET_DIV);
    localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);

    logic [NUM_CH-1:0][DIV_W-1:0] act_q, act_d;
    logic [NUM_CH-1:0][DIV_W-1:0] shd_q, shd_d;
    logic [NUM_CH-1:0][DIV_W-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0]            pend_q, pend_d;
    logic [NUM_CH-1:0]            tick_q, tick_d;
    logic [NUM_CH-1:0]            clk_q, clk_d;

    // Per-channel commit point and write decode (out-of-range indices never match).
    logic [NUM_CH-1:0]            commit_c;
    logic [NUM_CH-1:0]            wr_hit_c;

    // Next-state for every channel; all decisions use pre-edge register values.
    always_comb begin
        act_d    = act_q;
        shd_d    = shd_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        tick_d   = tick_q;
        clk_d    = clk_q;
        commit_c = '0;
        wr_hit_c = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_hit_c[i] = cfg_we_i && (int'(cfg_ch_i) == i);

            if (align_i) begin
                // Global restart: every channel back to phase zero, low output.
                cnt_d[i]    = '0;
                tick_d[i]   = 1'b0;
                clk_d[i]    = 1'b0;
                commit_c[i] = 1'b1;
            end else if (!en_i[i]) begin
                // Stopped: counter parked at zero, output level frozen.
                cnt_d[i]    = '0;
                tick_d[i]   = 1'b0;
                commit_c[i] = 1'b1;
            end else if (cnt_q[i] == act_q[i]) begin
                // Terminal count. C never exceeds A, so equality is sufficient.
                cnt_d[i]    = '0;
                tick_d[i]   = 1'b1;
                clk_d[i]    = ~clk_q[i];
                commit_c[i] = 1'b1;
            end else begin
                cnt_d[i]    = cnt_q[i] + ONE;
                tick_d[i]   = 1'b0;
            end

            // Commit takes the shadow as it was before this edge.
            if (commit_c[i] && pend_q[i]) begin
                act_d[i]  = shd_q[i];
                pend_d[i] = 1'b0;
            end

            // A write on the same edge lands in the shadow and stays pending.
            if (wr_hit_c[i]) begin
                shd_d[i]  = cfg_div_i;
                pend_d[i] = 1'b1;
            end
        end
    end

    // State registers; reset restores the default divisor and drops pending writes.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            act_q  <= {NUM_CH{RST_A}};
            shd_q  <= {NUM_CH{RST_A}};
            cnt_q  <= '0;
            pend_q <= '0;
            tick_q <= '0;
            clk_q  <= '0;
        end else begin
            act_q  <= act_d;
            shd_q  <= shd_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            tick_q <= tick_d;
            clk_q  <= clk_d;
        end
    end

    assign cfg_pend_o = pend_q;
    assign tick_o     = tick_q;
    assign clk_out_o  = clk_q;

endmodule

// File: tb/tb_fabosc_clkdiv_gen.sv
// Testbench for fabosc_clkdiv_gen: table vectors, directed corner sequences and
// randomized traffic compared against a period-length reference model.
module tb_fabosc_clkdiv_gen;

    localparam int NUM_CH    = 4;
    localparam int DIV_W     = 16;
    localparam int RESET_DIV = 49;
    localparam int CH_W      = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst   = 1'b0;
    logic [NUM_CH-1:0] en    = '0;
    logic              align = 1'b0;
    logic              we    = 1'b0;
    logic [CH_W-1:0]   ch    = '0;
    logic [DIV_W-1:0]  div   = '0;
    logic [NUM_CH-1:0] pend, tick, clko;

    // Secondary 3-channel instance, used for the out-of-range write index.
    logic [2:0]        en3 = '0;
    logic              we3 = 1'b0;
    logic [1:0]        ch3 = '0;
    logic [2:0]        pend3, tick3, clko3;

    int checks   = 0;
    int failures = 0;

    fabosc_clkdiv_gen #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .RESET_DIV(RESET_DIV)) dut (
        .clk_i(clk), .reset_i(rst), .en_i(en), .align_i(align),
        .cfg_we_i(we), .cfg_ch_i(ch), .cfg_div_i(div),
        .cfg_pend_o(pend), .tick_o(tick), .clk_out_o(clko)
    );

    fabosc_clkdiv_gen #(.NUM_CH(3), .DIV_W(DIV_W), .RESET_DIV(RESET_DIV)) dut3 (
        .clk_i(clk), .reset_i(rst), .en_i(en3), .align_i(align),
        .cfg_we_i(we3), .cfg_ch_i(ch3), .cfg_div_i(div),
        .cfg_pend_o(pend3), .tick_o(tick3), .clk_out_o(clko3)
    );

    // Reference model: per channel, count enabled edges in the current period
    // and fire when that count reaches divisor+1.
    int m_act [NUM_CH];
    int m_shd [NUM_CH];
    int m_run [NUM_CH];
    bit m_pend[NUM_CH];
    bit m_tick[NUM_CH];
    bit m_clk [NUM_CH];

    task automatic model_edge();
        for (int i = 0; i < NUM_CH; i++) begin
            bit restart;
            restart = 1'b0;
            if (rst) begin
                m_act[i] = RESET_DIV; m_shd[i] = RESET_DIV; m_run[i] = 0;
                m_pend[i] = 1'b0; m_tick[i] = 1'b0; m_clk[i] = 1'b0;
            end else begin
                if (align) begin
                    m_run[i] = 0; m_tick[i] = 1'b0; m_clk[i] = 1'b0; restart = 1'b1;
                end else if (!en[i]) begin
                    m_run[i] = 0; m_tick[i] = 1'b0; restart = 1'b1;
                end else begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == m_act[i] + 1) begin
                        m_tick[i] = 1'b1; m_clk[i] = !m_clk[i]; m_run[i] = 0; restart = 1'b1;
                    end else begin
                        m_tick[i] = 1'b0;
                    end
                end
                if (restart && m_pend[i]) begin
                    m_act[i] = m_shd[i]; m_pend[i] = 1'b0;
                end
                if (we && int'(ch) == i) begin
                    m_shd[i] = int'(div); m_pend[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic [NUM_CH-1:0] et, ec, ep;
        for (int i = 0; i < NUM_CH; i++) begin
            et[i] = m_tick[i]; ec[i] = m_clk[i]; ep[i] = m_pend[i];
        end
        check("model_tick", 32'(tick), 32'(et));
        check("model_clk",  32'(clko), 32'(ec));
        check("model_pend", 32'(pend), 32'(ep));
    endtask

    task automatic step(input bit chk);
        @(posedge clk);
        model_edge();
        #1;
        if (chk) compare_model();
    endtask

    task automatic do_reset();
        rst = 1'b1; en = '0; align = 1'b0; we = 1'b0; ch = '0; div = '0;
        en3 = '0; we3 = 1'b0; ch3 = '0;
        step(1'b1);
        check("reset_tick", 32'(tick), 32'd0);
        check("reset_clk",  32'(clko), 32'd0);
        check("reset_pend", 32'(pend), 32'd0);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  en;
        logic        align;
        logic        we;
        logic [1:0]  ch;
        logic [15:0] div;
        logic [3:0]  e_tick;
        logic [3:0]  e_clk;
        logic [3:0]  e_pend;
    } vec_t;

    vec_t tbl[11];

    initial begin
        // en, align, we, ch, div -> tick, clk_out, pend (after the edge)
        tbl[0]  = '{4'b0000, 1'b0, 1'b1, 2'd0, 16'd0, 4'b0000, 4'b0000, 4'b0001};
        tbl[1]  = '{4'b0000, 1'b0, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0000, 4'b0000};
        tbl[2]  = '{4'b0001, 1'b0, 1'b0, 2'd0, 16'd0, 4'b0001, 4'b0001, 4'b0000};
        tbl[3]  = '{4'b0001, 1'b0, 1'b0, 2'd0, 16'd0, 4'b0001, 4'b0000, 4'b0000};
        tbl[4]  = '{4'b0001, 1'b0, 1'b0, 2'd0, 16'd0, 4'b0001, 4'b0001, 4'b0000};
        tbl[5]  = '{4'b0000, 1'b0, 1'b1, 2'd1, 16'd1, 4'b0000, 4'b0001, 4'b0010};
        tbl[6]  = '{4'b0000, 1'b0, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0001, 4'b0000};
        tbl[7]  = '{4'b0011, 1'b1, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0000, 4'b0000};
        tbl[8]  = '{4'b0011, 1'b0, 1'b0, 2'd0, 16'd0, 4'b0001, 4'b0001, 4'b0000};
        tbl[9]  = '{4'b0011, 1'b0, 1'b0, 2'd0, 16'd0, 4'b0011, 4'b0010, 4'b0000};
        tbl[10] = '{4'b0011, 1'b0, 1'b0, 2'd0, 16'd0, 4'b0001, 4'b0011, 4'b0000};

        // Table: D=0 on ch0, EN drop freezes CLK_OUT, ALIGN, D=1 on ch1.
        do_reset();
        for (int v = 0; v < 11; v++) begin
            en = tbl[v].en; align = tbl[v].align; we = tbl[v].we;
            ch = tbl[v].ch; div = tbl[v].div;
            step(1'b1);
            check($sformatf("tbl%0d_tick", v), 32'(tick), 32'(tbl[v].e_tick));
            check($sformatf("tbl%0d_clk",  v), 32'(clko), 32'(tbl[v].e_clk));
            check($sformatf("tbl%0d_pend", v), 32'(pend), 32'(tbl[v].e_pend));
        end
        align = 1'b0; we = 1'b0;

        // Defaults: ticks at 50, 100, 150 enabled edges.
        do_reset();
        en = 4'b1111;
        for (int e = 1; e <= 150; e++) begin
            step(1'b1);
            if (e == 49)  check("def_tick49", 32'(tick), 32'd0);
            if (e == 50)  begin check("def_tick50", 32'(tick), 32'hF); check("def_clk50", 32'(clko), 32'hF); end
            if (e == 100) begin check("def_tick100", 32'(tick), 32'hF); check("def_clk100", 32'(clko), 32'h0); end
            if (e == 150) begin check("def_tick150", 32'(tick), 32'hF); check("def_pend150", 32'(pend), 32'h0); end
        end

        // Ch1 at D=9, rewrite to D=3 while C=5.
        do_reset();
        we = 1'b1; ch = 2'd1; div = 16'd9; step(1'b1);
        we = 1'b0; step(1'b1);
        en = 4'b0010;
        for (int e = 1; e <= 5; e++) step(1'b1);
        we = 1'b1; ch = 2'd1; div = 16'd3; step(1'b1);
        we = 1'b0;
        check("ch1_pend_set", 32'(pend[1]), 32'd1);
        for (int k = 1; k <= 12; k++) begin
            step(1'b1);
            check($sformatf("ch1_tick_k%0d", k), 32'(tick[1]), 32'((k == 4) || (k == 8) || (k == 12)));
            check($sformatf("ch1_pend_k%0d", k), 32'(pend[1]), 32'(k < 4));
        end

        // Ch2: write coinciding with terminal count commits the older shadow.
        do_reset();
        we = 1'b1; ch = 2'd2; div = 16'd4; step(1'b1);
        we = 1'b0; step(1'b1);
        en = 4'b0100;
        step(1'b1);
        we = 1'b1; div = 16'd7; step(1'b1);
        we = 1'b0; step(1'b1); step(1'b1);
        we = 1'b1; div = 16'd1; step(1'b1);
        we = 1'b0;
        check("ch2_tick5", 32'(tick[2]), 32'd1);
        check("ch2_pend5", 32'(pend[2]), 32'd1);
        for (int e = 6; e <= 17; e++) begin
            step(1'b1);
            check($sformatf("ch2_tick_e%0d", e), 32'(tick[2]), 32'((e == 13) || (e == 15) || (e == 17)));
            if (e == 12) check("ch2_pend12", 32'(pend[2]), 32'd1);
            if (e == 13) check("ch2_pend13", 32'(pend[2]), 32'd0);
        end

        // Ch0 D=2 and ch3 D=5, ALIGN mid-count.
        do_reset();
        we = 1'b1; ch = 2'd0; div = 16'd2; step(1'b1);
        ch = 2'd3; div = 16'd5; step(1'b1);
        we = 1'b0; step(1'b1);
        en = 4'b1001;
        for (int e = 1; e <= 4; e++) step(1'b1);
        align = 1'b1; step(1'b1);
        align = 1'b0;
        check("align_clk", 32'(clko), 32'd0);
        check("align_tick", 32'(tick), 32'd0);
        for (int k = 1; k <= 12; k++) begin
            step(1'b1);
            check($sformatf("align_t0_k%0d", k), 32'(tick[0]), 32'((k % 3) == 0));
            check($sformatf("align_t3_k%0d", k), 32'(tick[3]), 32'((k % 6) == 0));
        end

        // Out-of-range write index on the 3-channel instance, then mid-count reset.
        do_reset();
        we3 = 1'b1; ch3 = 2'd3; step(1'b1);
        we3 = 1'b0;
        check("oor_pend", 32'(pend3), 32'd0);
        check("oor_tick", 32'(tick3), 32'd0);
        we3 = 1'b1; ch3 = 2'd2; step(1'b1);
        we3 = 1'b0;
        check("inr_pend", 32'(pend3), 32'h4);
        check("inr_clk", 32'(clko3), 32'd0);
        en = 4'b1111;
        for (int e = 1; e <= 20; e++) step(1'b1);
        we = 1'b1; ch = 2'd0; div = 16'd5; step(1'b1);
        we = 1'b0;
        check("rst_pend_before", 32'(pend[0]), 32'd1);
        step(1'b1);
        rst = 1'b1; step(1'b1);
        rst = 1'b0;
        check("rst_mid_tick", 32'(tick), 32'd0);
        check("rst_mid_clk",  32'(clko), 32'd0);
        check("rst_mid_pend", 32'(pend), 32'd0);
        for (int e = 1; e <= 50; e++) begin
            step(1'b1);
            if (e == 49) check("rst_a49_e49", 32'(tick[0]), 32'd0);
            if (e == 50) check("rst_a49_e50", 32'(tick[0]), 32'd1);
        end

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NUM_CH; i++) en[i] = ($urandom_range(0, 7) != 0);
            align = ($urandom_range(0, 99) == 0);
            we    = ($urandom_range(0, 9) == 0);
            ch    = CH_W'($urandom_range(0, NUM_CH - 1));
            div   = ($urandom_range(0, 15) == 0) ? DIV_W'($urandom_range(0, 200))
                                                 : DIV_W'($urandom_range(0, 6));
            rst   = ($urandom_range(0, 999) == 0);
            step(1'b1);
        end
        rst = 1'b0; align = 1'b0; we = 1'b0;

        // Maximum divisor: counter reaches all-ones and returns to zero.
        do_reset();
        we = 1'b1; ch = 2'd0; div = 16'hFFFF; step(1'b1);
        we = 1'b0; step(1'b1);
        en = 4'b0001;
        for (int e = 1; e <= 65536; e++) begin
            step(1'b0);
            if (e == 65535) check("max_tick_pre", 32'(tick[0]), 32'd0);
            if (e == 65536) check("max_tick", 32'(tick[0]), 32'd1);
        end
        step(1'b1);
        check("max_after", 32'(tick[0]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
